obi_soc_demux: RTL and testbench
================================

Name: obi_soc_demux

Overview:
- Parametrised OBI 1-to-N address demultiplexer between the CPU-side unified OBI bus (output of the instruction/data arbiter) and N SoC targets: DRAM, IRAM, UART, and the external WB bridge.
- Replaces the hard-wired chip_sel/block_sel decode and the ad-hoc gnt/rvalid registers with a table-driven address map.
- Tracks outstanding transactions so each response returns from the correct target, in order.
- Answers unmapped addresses with an OBI error response.

Parameters:
- NUM_SLAVES, 4, number of target ports (index 0..NUM_SLAVES-1)
- ADDR_WIDTH, 32, OBI address width
- DATA_WIDTH, 32, OBI data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, accepted-but-unanswered transactions allowed (>=1)
- SLAVE_BASE, {32'h0010_0000, 32'h0040_0000, 32'h0008_0000, 32'h0000_0000}, NUM_SLAVES*ADDR_WIDTH packed base addresses; slice i = slave i
- SLAVE_MASK, {32'hFFF8_0000, 32'hFFC0_0000, 32'hFFF8_0000, 32'hFFF8_0000}, packed decode masks; slave i hit when (addr & MASK[i]) == BASE[i]

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- m_req_i  in  1  master request
- m_gnt_o  out  1  master grant
- m_addr_i  in  ADDR_WIDTH  master address
- m_we_i  in  1  write enable
- m_be_i  in  DATA_WIDTH/8  byte enables
- m_wdata_i  in  DATA_WIDTH  write data
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  DATA_WIDTH  response data
- m_err_o  out  1  response error, qualified by m_rvalid_o
- s_req_o  out  NUM_SLAVES  per-target request
- s_gnt_i  in  NUM_SLAVES  per-target grant
- s_addr_o  out  ADDR_WIDTH  broadcast address (= m_addr_i)
- s_we_o  out  1  broadcast write enable
- s_be_o  out  DATA_WIDTH/8  broadcast byte enables
- s_wdata_o  out  DATA_WIDTH  broadcast write data
- s_rvalid_i  in  NUM_SLAVES  per-target response valid
- s_rdata_i  in  NUM_SLAVES*DATA_WIDTH  packed response data
- spurious_o  out  1  sticky flag: rvalid from a non-expected target

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
  - During reset: FIFO empty, count=0, error-response register clear, spurious_o=0.
  - Combinational outputs follow from that state: m_gnt_o=0 unless a target grants, m_rvalid_o=0, m_rdata_o=0, m_err_o=0, s_req_o=0 when m_req_i=0.
- Decode (combinational):
  - tgt = lowest index i that hits; if none hits, tgt = ERR_ID (= NUM_SLAVES, the internal error target).
- Stall (combinational): asserted when either
  - count == MAX_OUTSTANDING (no same-cycle pop bypass), or
  - count != 0 and tgt != ID of the youngest outstanding entry.
  - This keeps responses in order without a reorder buffer.
- Request path, zero added latency:
  - s_req_o[i] = m_req_i & (tgt==i) & !stall.
  - m_gnt_o = !stall & m_req_i & (tgt==ERR_ID ? 1 : s_gnt_i[tgt]).
  - Error target grants in the same cycle.
- Accept: the cycle m_req_i & m_gnt_o holds, push tgt into the ID FIFO.
- Response path, zero added latency:
  - head = oldest FIFO entry.
  - m_rvalid_o = count!=0 & (head==ERR_ID ? err_pending : s_rvalid_i[head]).
  - m_rdata_o = selected slice of s_rdata_i, or 0 for the error target.
  - m_err_o = (head==ERR_ID).
  - Pop on m_rvalid_o.
- Error target: err_pending sets on the accept cycle and clears on pop. Its rvalid is therefore exactly 1 cycle after gnt.
- Push and pop in the same cycle: allowed, count unchanged. Count width is $clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.
- Spurious response: s_rvalid_i[j] with count==0 or j != head.
  - Ignored for routing.
  - Sets spurious_o, which clears only on reset.
  - Covers stale responses that arrive after a reset mid-operation.
- Slave-side broadcast signals are pure wires; targets qualify them with s_req_o.
- Master address, we, be and wdata must be held stable while m_req_i & !m_gnt_o. Per OBI, the block does not check this.

Decomposition:
- Package soc_map_pkg holds:
  - default base/mask localparams;
  - slave index constants (DRAM=0, IRAM=1, EXT_WB=2, UART=3);
  - the target-ID typedef, width $clog2(NUM_SLAVES+1).
- Sub-module obi_id_fifo: ID FIFO holding the target index, depth MAX_OUTSTANDING. It exposes head, tail, count, and push/pop.

Test Plan:
- Read 0x0000_0010 with DRAM granting immediately and rvalid 1 cycle later with rdata 0xDEAD_BEEF -> s_req_o=4'b0001; m_gnt_o in cycle 0; m_rvalid_o=1, m_rdata_o=0xDEAD_BEEF, m_err_o=0 in cycle 1.
- Write to 0x0040_0004 with EXT_WB holding s_gnt_i low for 3 cycles -> m_gnt_o low 3 cycles, s_req_o[2] held high, single accept, count peaks at 1.
- Back-to-back reads 0x0008_0000 then 0x0000_0000 (different targets) -> the second request stalls (s_req_o=0) until the IRAM response pops, then is granted.
- Three pipelined reads to DRAM with rvalid delayed, MAX_OUTSTANDING=2 -> third request stalls until the first response; responses return in order.
- Read 0x0100_0000 (unmapped) -> m_gnt_o same cycle, no s_req_o asserted, m_rvalid_o=1, m_err_o=1, m_rdata_o=0 one cycle later.
- Assert rst_ni low with 2 outstanding, release it, then the UART raises s_rvalid_i[3] -> m_rvalid_o stays 0 and spurious_o=1.

Source files
------------

// File: rtl/soc_map_pkg.sv
// ---------------------------------------------------------------------------
// soc_map_pkg
// Purpose : SoC address map shared by the OBI demultiplexer and its users.
//           Holds the default base/mask table, the slave index constants and
//           the target-ID type (slave index, plus one extra code for the
//           internal error target).
// Contents: SOC_NUM_SLAVES, SOC_ADDR_W, SLV_* indices, SOC_SLAVE_BASE,
//           SOC_SLAVE_MASK, TGT_ID_W / tgt_id_t, soc_addr_hit().
// ---------------------------------------------------------------------------
package soc_map_pkg;

    localparam int unsigned SOC_NUM_SLAVES = 4;
    localparam int unsigned SOC_ADDR_W     = 32;

    // Slave port indices
    localparam int unsigned SLV_DRAM   = 0;
    localparam int unsigned SLV_IRAM   = 1;
    localparam int unsigned SLV_EXT_WB = 2;
    localparam int unsigned SLV_UART   = 3;

    // Packed tables, slice i belongs to slave i (slice 0 is the rightmost).
    //   DRAM   0x0000_0000 - 0x0007_FFFF
    //   IRAM   0x0008_0000 - 0x000F_FFFF
    //   EXT_WB 0x0040_0000 - 0x007F_FFFF
    //   UART   0x0010_0000 - 0x0017_FFFF
    localparam logic [SOC_NUM_SLAVES*SOC_ADDR_W-1:0] SOC_SLAVE_BASE =
        {32'h0010_0000, 32'h0040_0000, 32'h0008_0000, 32'h0000_0000};
    localparam logic [SOC_NUM_SLAVES*SOC_ADDR_W-1:0] SOC_SLAVE_MASK =
        {32'hFFF8_0000, 32'hFFC0_0000, 32'hFFF8_0000, 32'hFFF8_0000};

    // Target ID: 0..NUM_SLAVES-1 are real slaves, NUM_SLAVES is the error target.
    localparam int unsigned TGT_ID_W = $clog2(SOC_NUM_SLAVES + 1);
    typedef logic [TGT_ID_W-1:0] tgt_id_t;

    // Single-window decode for the default address width.
    function automatic logic soc_addr_hit(input logic [SOC_ADDR_W-1:0] addr,
                                          input logic [SOC_ADDR_W-1:0] base,
                                          input logic [SOC_ADDR_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// ---------------------------------------------------------------------------
// obi_id_fifo
// Purpose : Small FIFO of target IDs for outstanding OBI transactions. The
//           demux pushes the target on every accepted request and pops on
//           every delivered response, so the head always names the target
//           that owes the next response.
// Ports   : clk_i, rst_ni   clock, async active-low reset
//           push_i, data_i  write one ID (caller guarantees not full)
//           pop_i           drop the oldest ID (caller guarantees not empty)
//           head_o          oldest ID
//           tail_o          youngest ID
//           count_o         number of stored IDs (0..DEPTH)
// ---------------------------------------------------------------------------
module obi_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 3,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [W-1:0]  tail_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) count_d = count_q + CW'(1);
        if (!push_i && pop_i) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    // Youngest entry sits just behind the write pointer.
    assign tail_o  = (wr_ptr_q == '0) ? mem_q[LAST] : mem_q[wr_ptr_q - PW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/obi_soc_demux.sv
// ---------------------------------------------------------------------------
// obi_soc_demux
// Purpose : OBI 1-to-N address demultiplexer from the unified CPU bus to the
//           SoC targets (DRAM, IRAM, EXT_WB, UART). Table-driven decode, zero
//           added latency on request and response, in-order responses via an
//           ID FIFO, OBI error responses for unmapped addresses, and a sticky
//           flag for responses nobody asked for.
// Ports   : clk_i, rst_ni                 clock, async active-low reset
//           m_req_i/m_gnt_o/m_addr_i/m_we_i/m_be_i/m_wdata_i   master A-channel
//           m_rvalid_o/m_rdata_o/m_err_o  master R-channel
//           s_req_o/s_gnt_i               per-target request / grant
//           s_addr_o/s_we_o/s_be_o/s_wdata_o  broadcast A-channel payload
//           s_rvalid_i/s_rdata_i          per-target response (rdata packed)
//           spurious_o                    sticky unexpected-rvalid flag
// ---------------------------------------------------------------------------
module obi_soc_demux
    import soc_map_pkg::*;
#(
    parameter int unsigned NUM_SLAVES      = SOC_NUM_SLAVES,
    parameter int unsigned ADDR_WIDTH      = SOC_ADDR_W,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = SOC_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = SOC_SLAVE_MASK
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    // master side
    input  logic                             m_req_i,
    output logic                             m_gnt_o,
    input  logic [ADDR_WIDTH-1:0]            m_addr_i,
    input  logic                             m_we_i,
    input  logic [DATA_WIDTH/8-1:0]          m_be_i,
    input  logic [DATA_WIDTH-1:0]            m_wdata_i,
    output logic                             m_rvalid_o,
    output logic [DATA_WIDTH-1:0]            m_rdata_o,
    output logic                             m_err_o,
    // slave side
    output logic [NUM_SLAVES-1:0]            s_req_o,
    input  logic [NUM_SLAVES-1:0]            s_gnt_i,
    output logic [ADDR_WIDTH-1:0]            s_addr_o,
    output logic                             s_we_o,
    output logic [DATA_WIDTH/8-1:0]          s_be_o,
    output logic [DATA_WIDTH-1:0]            s_wdata_o,
    input  logic [NUM_SLAVES-1:0]            s_rvalid_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
    output logic                             spurious_o
);

    localparam int unsigned IDW = $clog2(NUM_SLAVES + 1);
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDW-1:0] ERR_ID  = IDW'(NUM_SLAVES);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [NUM_SLAVES-1:0] hit;
    logic [IDW-1:0]        tgt;
    logic [IDW-1:0]        head, tail;
    logic [CW-1:0]         count;
    logic                  busy;
    logic                  stall;
    logic                  tgt_gnt;
    logic                  accept;
    logic                  pop;
    logic                  head_rvalid;
    logic [DATA_WIDTH-1:0] head_rdata;
    logic [NUM_SLAVES-1:0] rvalid_expected;
    logic                  err_pending_q, err_pending_d;
    logic                  spurious_q, spurious_d;

    // ---------------- decode ----------------
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_hit
        assign hit[i] = (m_addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                        == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Scan downward so the lowest hitting index wins overlapping windows.
    always_comb begin
        tgt = ERR_ID;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) tgt = IDW'(i);
        end
    end

    // ---------------- request path ----------------
    assign busy = (count != '0);

    // Only one target may have responses in flight at a time; switching
    // targets waits for the pipe to drain so responses cannot overtake.
    assign stall = (count == MAX_CNT) || (busy && (tgt != tail));

    always_comb begin
        tgt_gnt = (tgt == ERR_ID);
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (tgt == IDW'(i)) tgt_gnt = s_gnt_i[i];
        end
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_req
        assign s_req_o[i] = m_req_i && (tgt == IDW'(i)) && !stall;
    end

    assign m_gnt_o = m_req_i && !stall && tgt_gnt;
    assign accept  = m_req_i && m_gnt_o;

    assign s_addr_o  = m_addr_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_wdata_o = m_wdata_i;

    // ---------------- outstanding-ID tracking ----------------
    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDW),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (tgt),
        .pop_i   (pop),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count)
    );

    // ---------------- response path ----------------
    always_comb begin
        head_rvalid     = (head == ERR_ID) && err_pending_q;
        head_rdata      = '0;
        rvalid_expected = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (head == IDW'(i)) begin
                head_rvalid        = s_rvalid_i[i];
                head_rdata         = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                rvalid_expected[i] = busy;
            end
        end
    end

    assign m_rvalid_o = busy && head_rvalid;
    assign pop        = m_rvalid_o;
    // Gated by busy so a stale head never leaks data or error after reset.
    assign m_rdata_o  = busy ? head_rdata : '0;
    assign m_err_o    = busy && (head == ERR_ID);

    // The error target answers the cycle after its grant. A new error accept
    // in the same cycle as the previous error pop must leave it set.
    always_comb begin
        err_pending_d = err_pending_q;
        if (pop && (head == ERR_ID)) err_pending_d = 1'b0;
        if (accept && (tgt == ERR_ID)) err_pending_d = 1'b1;
    end

    assign spurious_d = spurious_q || |(s_rvalid_i & ~rvalid_expected);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_pending_q <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            err_pending_q <= err_pending_d;
            spurious_q    <= spurious_d;
        end
    end

    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_obi_soc_demux.sv
module tb_obi_soc_demux;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              m_req_i;
    logic              m_gnt_o;
    logic [31:0]       m_addr_i;
    logic              m_we_i;
    logic [3:0]        m_be_i;
    logic [31:0]       m_wdata_i;
    logic              m_rvalid_o;
    logic [31:0]       m_rdata_o;
    logic              m_err_o;
    logic [3:0]        s_req_o;
    logic [3:0]        s_gnt_i;
    logic [31:0]       s_addr_o;
    logic              s_we_o;
    logic [3:0]        s_be_o;
    logic [31:0]       s_wdata_o;
    logic [3:0]        s_rvalid_i;
    logic [3:0][31:0]  s_rdata_i;
    logic              spurious_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    obi_soc_demux dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .m_req_i    (m_req_i),
        .m_gnt_o    (m_gnt_o),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_gnt_i    (s_gnt_i),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .spurious_o (spurious_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m_req_i    = 1'b0;
        m_addr_i   = '0;
        m_we_i     = 1'b0;
        m_be_i     = 4'hF;
        m_wdata_i  = '0;
        s_gnt_i    = '0;
        s_rvalid_i = '0;
        s_rdata_i  = '0;
    endtask

    task automatic req(input logic [31:0] addr, input logic we, input logic [3:0] gnt);
        m_req_i   = 1'b1;
        m_addr_i  = addr;
        m_we_i    = we;
        m_wdata_i = addr ^ 32'h5A5A_5A5A;
        s_gnt_i   = gnt;
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Monitor: every response the DUT presents is checked against the oldest
    // expectation queued by the stimulus.
    always @(negedge clk_i) begin
        if (rst_ni && m_rvalid_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rvalid: rdata=0x%08h err=%0b, no response outstanding",
                         m_rdata_o, m_err_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (m_rdata_o !== e.rdata || m_err_o !== e.err) begin
                    n_bad++;
                    $display("FAIL rsp: rdata=0x%08h err=%0b, expected rdata=0x%08h err=%0b",
                             m_rdata_o, m_err_o, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        idle();
        rst_ni = 1'b0;
        #1;
        // ---- reset state ----
        chk("rst_gnt",      32'(m_gnt_o),    0);
        chk("rst_rvalid",   32'(m_rvalid_o), 0);
        chk("rst_rdata",    m_rdata_o,       0);
        chk("rst_err",      32'(m_err_o),    0);
        chk("rst_sreq",     32'(s_req_o),    0);
        chk("rst_spurious", 32'(spurious_o), 0);
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc();

        // ---- 1: DRAM read, immediate grant, rvalid next cycle ----
        req(32'h0000_0010, 1'b0, 4'b0001);
        #1;
        chk("t1_sreq", 32'(s_req_o), 32'b0001);
        chk("t1_gnt",  32'(m_gnt_o), 1);
        chk("t1_saddr", s_addr_o, 32'h0000_0010);
        expect_rsp(32'hDEAD_BEEF, 1'b0);
        cyc();
        idle();
        s_rvalid_i   = 4'b0001;
        s_rdata_i[0] = 32'hDEAD_BEEF;
        #1;
        chk("t1_rvalid", 32'(m_rvalid_o), 1);
        chk("t1_rdata",  m_rdata_o, 32'hDEAD_BEEF);
        cyc();
        idle();
        cyc();

        // ---- 2: EXT_WB write, grant withheld 3 cycles ----
        for (int i = 0; i < 3; i++) begin
            req(32'h0040_0004, 1'b1, 4'b0000);
            #1;
            chk("t2_wait_gnt",  32'(m_gnt_o), 0);
            chk("t2_wait_sreq", 32'(s_req_o), 32'b0100);
            cyc();
        end
        req(32'h0040_0004, 1'b1, 4'b0100);
        #1;
        chk("t2_gnt",  32'(m_gnt_o), 1);
        chk("t2_we",   32'(s_we_o),  1);
        chk("t2_wdata", s_wdata_o, 32'h0040_0004 ^ 32'h5A5A_5A5A);
        expect_rsp(32'h0000_0000, 1'b0);
        cyc();
        idle();
        s_rvalid_i = 4'b0100;
        #1;
        chk("t2_rvalid", 32'(m_rvalid_o), 1);
        cyc();
        idle();
        #1;
        chk("t2_no_extra", 32'(m_rvalid_o), 0);
        cyc();

        // ---- 3: IRAM read then DRAM read: target switch waits for drain ----
        req(32'h0008_0000, 1'b0, 4'b0010);
        #1;
        chk("t3_sreq_a", 32'(s_req_o), 32'b0010);
        chk("t3_gnt_a",  32'(m_gnt_o), 1);
        expect_rsp(32'h1111_1111, 1'b0);
        cyc();
        req(32'h0000_0000, 1'b0, 4'b0001);
        #1;
        chk("t3_stall_sreq", 32'(s_req_o), 0);
        chk("t3_stall_gnt",  32'(m_gnt_o), 0);
        cyc();
        s_rvalid_i   = 4'b0010;
        s_rdata_i[1] = 32'h1111_1111;
        #1;
        chk("t3_nobypass_sreq", 32'(s_req_o), 0);
        chk("t3_nobypass_gnt",  32'(m_gnt_o), 0);
        cyc();
        s_rvalid_i = '0;
        #1;
        chk("t3_sreq_b", 32'(s_req_o), 32'b0001);
        chk("t3_gnt_b",  32'(m_gnt_o), 1);
        expect_rsp(32'h2222_2222, 1'b0);
        cyc();
        idle();
        s_rvalid_i   = 4'b0001;
        s_rdata_i[0] = 32'h2222_2222;
        cyc();
        idle();
        cyc();

        // ---- 4: three pipelined DRAM reads, depth 2 ----
        req(32'h0000_0100, 1'b0, 4'b0001);
        #1;
        chk("t4_gnt1", 32'(m_gnt_o), 1);
        expect_rsp(32'hA000_0001, 1'b0);
        cyc();
        req(32'h0000_0104, 1'b0, 4'b0001);
        #1;
        chk("t4_gnt2", 32'(m_gnt_o), 1);
        expect_rsp(32'hA000_0002, 1'b0);
        cyc();
        req(32'h0000_0108, 1'b0, 4'b0001);
        #1;
        chk("t4_full_sreq", 32'(s_req_o), 0);
        chk("t4_full_gnt",  32'(m_gnt_o), 0);
        cyc();
        #1;
        chk("t4_full_gnt2", 32'(m_gnt_o), 0);
        cyc();
        s_rvalid_i   = 4'b0001;
        s_rdata_i[0] = 32'hA000_0001;
        #1;
        chk("t4_pop_nobypass", 32'(m_gnt_o), 0);
        cyc();
        s_rvalid_i = '0;
        #1;
        chk("t4_gnt3", 32'(m_gnt_o), 1);
        expect_rsp(32'hA000_0003, 1'b0);
        cyc();
        idle();
        s_rvalid_i   = 4'b0001;
        s_rdata_i[0] = 32'hA000_0002;
        cyc();
        s_rdata_i[0] = 32'hA000_0003;
        cyc();
        idle();
        cyc();

        // ---- 5: unmapped read -> error response ----
        req(32'h0100_0000, 1'b0, 4'b0000);
        #1;
        chk("t5_gnt",  32'(m_gnt_o), 1);
        chk("t5_sreq", 32'(s_req_o), 0);
        expect_rsp(32'h0000_0000, 1'b1);
        cyc();
        idle();
        s_rdata_i = {4{32'hFFFF_FFFF}};
        #1;
        chk("t5_rvalid", 32'(m_rvalid_o), 1);
        chk("t5_err",    32'(m_err_o),    1);
        chk("t5_rdata",  m_rdata_o,       0);
        cyc();
        idle();
        #1;
        chk("t5_done", 32'(m_rvalid_o), 0);
        chk("pre6_spurious", 32'(spurious_o), 0);
        cyc();

        // ---- 6: reset with two UART reads outstanding, stale rvalid ----
        req(32'h0010_0000, 1'b0, 4'b1000);
        #1;
        chk("t6_sreq", 32'(s_req_o), 32'b1000);
        chk("t6_gnt1", 32'(m_gnt_o), 1);
        cyc();
        req(32'h0010_0004, 1'b0, 4'b1000);
        #1;
        chk("t6_gnt2", 32'(m_gnt_o), 1);
        cyc();
        idle();
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_rvalid", 32'(m_rvalid_o), 0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        s_rvalid_i   = 4'b1000;
        s_rdata_i[3] = 32'h3333_3333;
        #1;
        chk("t6_stale_rvalid", 32'(m_rvalid_o), 0);
        chk("t6_stale_rdata",  m_rdata_o,       0);
        cyc();
        s_rvalid_i = '0;
        #1;
        chk("t6_spurious", 32'(spurious_o), 1);
        cyc();
        #1;
        chk("t6_spurious_sticky", 32'(spurious_o), 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
